// File: rtl/cache_arbiter.sv
// Shares the 4-entry LRU data cache between the fetch (F) and data (D) requesters,
// one latched access at a time, with hit/miss statistics and a WAIT watchdog.
module cache_arbiter #(
    parameter int d_width  = 8,
    parameter int a_width  = 8,
    parameter int wd_limit = 31
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               f_req,
    input  logic [a_width-1:0] f_addr,
    output logic               f_ack,
    output logic [d_width-1:0] f_rdata,
    input  logic               d_req,
    input  logic               d_rw,
    input  logic [a_width-1:0] d_addr,
    input  logic [d_width-1:0] d_wdata,
    output logic               d_ack,
    output logic [d_width-1:0] d_rdata,
    output logic               c_enab,
    output logic               c_rw,
    output logic [a_width-1:0] c_addr,
    output logic [d_width-1:0] c_wdata,
    input  logic [d_width-1:0] c_rdata,
    input  logic               c_hit,
    input  logic [3:0]         c_state,
    output logic               grant,
    output logic               busy,
    output logic               err,
    output logic [7:0]         hit_cnt,
    output logic [7:0]         miss_cnt
);
    localparam int WD_W = $clog2(wd_limit + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [d_width-1:0] wdata_q, wdata_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [d_width-1:0] f_rdata_q, f_rdata_d;
    logic [d_width-1:0] d_rdata_q, d_rdata_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               err_q, err_d;
    logic [7:0]         hit_cnt_q, hit_cnt_d;
    logic [7:0]         miss_cnt_q, miss_cnt_d;
    logic               pick;

    // Handshake: a requester holds req high until its ack; ack is a single-cycle
    // pulse in DONE, and a req still high in the following IDLE is a new request.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        wd_cnt_d     = wd_cnt_q;
        err_d        = err_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        pick         = 1'b0;
        c_enab       = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    pick         = (f_req && d_req) ? ~last_grant_q : d_req;
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? d_addr : f_addr;
                    rw_d         = pick ? d_rw : 1'b0;
                    wdata_d      = pick ? d_wdata : wdata_q;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                c_enab   = 1'b1;
                wd_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // Follows the cache so a return to state 0 never starts a second access.
                c_enab = (c_state != 4'd0);
                if (wd_cnt_q == '0 && c_state == 4'd1) begin
                    if (c_hit) begin
                        if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
                    end else begin
                        if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
                if (c_state == 4'd0) begin
                    if (!rw_q) begin
                        if (grant_q) d_rdata_d = c_rdata;
                        else         f_rdata_d = c_rdata;
                    end
                    state_d = DONE;
                end else if (wd_cnt_q == WD_W'(wd_limit - 1)) begin
                    err_d   = 1'b1;
                    c_enab  = 1'b0;
                    state_d = DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            wd_cnt_q     <= '0;
            err_q        <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            wd_cnt_q     <= wd_cnt_d;
            err_q        <= err_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign f_ack    = (state_q == DONE) && !grant_q;
    assign d_ack    = (state_q == DONE) && grant_q;
    assign f_rdata  = f_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign c_rw     = rw_q;
    assign c_addr   = addr_q;
    assign c_wdata  = wdata_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter and sequencer for the 4-entry fully associative LRU data cache of the accumulator processor. It shares the cache between an instruction-fetch requester (F, read-only) and a data requester (D, read/write). It latches one request at a time and drives the cache's enab/rw/Addr/data_in. Completion is detected from the cache's state output, and the block returns read data with a one-cycle ack pulse. It also keeps hit/miss statistics and a watchdog.

## Interface
- d_width, 8, data width (matches cache)
- a_width, 8, address width (matches cache)
- wd_limit, 31, maximum cycles in WAIT before abort (fits 5-bit counter)

Ports:
- clk  in  1  system clock; all state changes on posedge
- clr  in  1  reset; one clock; reset is synchronous and active-high
- f_req  in  1  fetch request; held high until f_ack
- f_addr  in  a_width  fetch address
- f_ack  out  1  one-cycle completion pulse to F
- f_rdata  out  d_width  fetch read data, valid with f_ack, held until next F completion
- d_req  in  1  data request; held high until d_ack
- d_rw  in  1  0 = read, 1 = write
- d_addr  in  a_width  data address
- d_wdata  in  d_width  write data
- d_ack  out  1  one-cycle completion pulse to D
- d_rdata  out  d_width  data read data, valid with d_ack on reads, held until next D read
- c_enab, c_rw  out  1  to cache enab, rw
- c_addr  out  a_width  to cache Addr
- c_wdata  out  d_width  to cache data_in
- c_rdata  in  d_width  from cache data_out
- c_hit  in  1  from cache hit_out
- c_state  in  4  from cache state
- grant  out  1  owner of current/last transaction: 0 = F, 1 = D
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog flag, cleared only by clr
- hit_cnt, miss_cnt  out  8  saturating counters (stop at 255)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last (round-robin; last_grant resets to D, so F wins the first tie).
  - On grant, latch addr, rw (F forces rw = 0) and wdata into internal registers, set grant and last_grant, then go to ISSUE.
- **ISSUE:** one cycle. c_enab = 1. Go to WAIT. Clear the watchdog counter.
- **WAIT:**
  - c_enab = (c_state != 0), combinational, so the cache never starts a second access when it returns to state 0.
  - In the first WAIT cycle (c_state == 1), sample c_hit. If 1, hit_cnt += 1, else miss_cnt += 1 (both saturating).
  - When c_state == 0, capture c_rdata into the granted port's rdata register (reads only), then go to DONE.
  - Watchdog counter increments each WAIT cycle. On reaching wd_limit: set err, drop c_enab, go to DONE with no rdata update.
- **DONE:** pulse the granted port's ack for one cycle, then go to IDLE.
  - A requester whose req is still high in the following IDLE cycle is arbitrated as a new request.
- c_addr, c_rw and c_wdata come from the latched registers and are stable from ISSUE through DONE. A requester changing its inputs after the grant has no effect.
- Outside ISSUE and WAIT, c_enab = 0.

## Timing
- **Reset values:**
  - FSM = IDLE, c_enab = 0, c_rw = 0, c_addr = 0, c_wdata = 0
  - f_ack = d_ack = 0, f_rdata = d_rdata = 0
  - grant = 0, busy = 0, err = 0, hit_cnt = miss_cnt = 0, last_grant = D
- **Hit latency** (cycle 0 = IDLE cycle in which req is sampled high):
  - ISSUE cycle 1, c_state = 1 in cycle 2, c_state = 0 in cycle 3 (capture), ack in cycle 4.
- **Miss latency:** the cache passes through 11 nonzero states (read: 1,2,3,4,5,8–13; write: 1,2,3,6,7,8–12,14). The result is captured in cycle 13 and ack is asserted in cycle 14.
- **Back-to-back:** minimum spacing between acks of consecutive transactions is 5 cycles.
- **Reset mid-transaction:** clr in any state forces IDLE next cycle with c_enab = 0, which returns the cache to state 0. No ack is issued for the aborted transaction. Counters clear.
- A req that falls before its ack is a protocol violation; the transaction still completes and acks.

## Test plan
- **Reset:** clr high 2 cycles mid-WAIT of a miss -> all outputs at reset values, c_enab = 0, no ack; next F read completes normally.
- **F read miss:** F read miss at 0x05 after cache cleared -> f_ack at cycle 14, f_rdata = RAM[5], miss_cnt = 1, busy low cycle 15.
- **D write then read:** D write 0xA5 to 0x03 (miss), then D read 0x03 -> second d_ack at cycle 4 of its transaction, d_rdata = 0xA5, hit_cnt = 1.
- **Simultaneous requests:** f_req and d_req high together, both held -> F granted first (grant = 0), D next (grant = 1), then F again; acks never overlap.
- **Watchdog:** c_state forced to 5 constantly during WAIT -> err = 1 after 31 WAIT cycles, ack pulses, rdata unchanged, c_enab = 0.
- **Saturation:** 260 hits to the same address -> hit_cnt holds at 255.
